// File: rtl/aes_key_pkg.sv
// Shared types and constants for the AES round-key store.
// Optional forwarding path: ROUND_KEY_STORE_BYPASS_EN.
package aes_key_pkg;
   localparam int SUBKEY_W  = 128;
   localparam int KS_DEPTH  = 15;
   localparam int KS_ADDR_W = 4;

   localparam logic [1:0] KEY_LEN_NONE = 2'b00;
   localparam logic [1:0] KEY_LEN_128  = 2'b01;
   localparam logic [1:0] KEY_LEN_192  = 2'b10;
   localparam logic [1:0] KEY_LEN_256  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_READY
   } ks_state_e;

   function automatic logic [KS_ADDR_W-1:0] last_round(input logic [1:0] key_len);
      logic [KS_ADDR_W-1:0] r;
      unique case (1'b1)
         key_len == KEY_LEN_128: r = 4'd10;
         key_len == KEY_LEN_192: r = 4'd12;
         key_len == KEY_LEN_256: r = 4'd14;
         default:                r = 4'd0;
      endcase
      return r;
   endfunction
endpackage

// File: rtl/round_key_ram.sv
// Round-key storage array: one write port, one registered read port.
// Array is not reset; only the read register is.
module round_key_ram #(
   parameter int W  = 128,
   parameter int D  = 15,
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   input  logic          fwd_i,
   input  logic [W-1:0]  fwd_data_i,
   output logic [W-1:0]  rdata_o
);
   logic [W-1:0] mem_q [D];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Read-before-write: a same-cycle write is only seen via fwd_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= fwd_i ? fwd_data_i : mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/round_key_store.sv
// Captures expanded round keys and serves them to the round pipeline.
// Define ROUND_KEY_STORE_BYPASS_EN to forward same-cycle writes to reads.
module round_key_store #(
   parameter int SUBKEY_W = 128,
   parameter int DEPTH    = 15,
   parameter int ADDR_W   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_clear,
   input  logic [1:0]          key_len,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [SUBKEY_W-1:0] wr_data,
   input  logic                rd_req,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic                rd_stall,
   output logic                rd_valid,
   output logic [SUBKEY_W-1:0] rd_data,
   output logic                rd_err,
   output logic                keys_ready,
   output logic                busy
);
   import aes_key_pkg::*;

   localparam int NADDR = 1 << ADDR_W;

   ks_state_e         state_q;
   logic [DEPTH-1:0]  valid_q;
   logic [1:0]        key_len_q;
   logic [ADDR_W-1:0] count_q;
   logic              rd_valid_q;
   logic              rd_err_q;
   logic              keys_ready_q;
   logic              busy_q;

   logic [ADDR_W-1:0] last;
   logic [NADDR-1:0]  vld;
   logic              full;
   logic              wr_acc;
   logic              wr_new;
   logic              rd_in;
   logic              rd_live;
   logic              rd_hit;
   logic              rd_fwd;
   logic              rd_bad;

   assign last = last_round(key_len_q);
   assign vld  = {{(NADDR-DEPTH){1'b0}}, valid_q};
   assign full = count_q == (last + ADDR_W'(1));

   assign wr_acc = wr_en && !wr_clear &&
                   state_q == ST_LOAD && wr_addr <= last;
   assign wr_new = wr_acc && !vld[wr_addr];

   assign rd_in   = rd_addr <= last;
   assign rd_live = rd_req && !wr_clear;
   assign rd_hit  = rd_live && state_q != ST_IDLE &&
                    rd_in && vld[rd_addr];
   assign rd_bad  = rd_live && (state_q == ST_IDLE || !rd_in);

`ifdef ROUND_KEY_STORE_BYPASS_EN
   assign rd_fwd = rd_live && state_q != ST_IDLE && rd_in &&
                   !vld[rd_addr] && wr_acc && wr_addr == rd_addr;
`else
   assign rd_fwd = 1'b0;
`endif

   // A clear in the same cycle also lands here: hit/fwd/bad are all low.
   assign rd_stall = rd_req && !rd_hit && !rd_fwd && !rd_bad;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         valid_q      <= '0;
         key_len_q    <= KEY_LEN_NONE;
         count_q      <= '0;
         rd_valid_q   <= 1'b0;
         rd_err_q     <= 1'b0;
         keys_ready_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rd_valid_q <= rd_hit || rd_fwd;
         rd_err_q   <= rd_bad;
         if (wr_clear) begin
            valid_q      <= '0;
            key_len_q    <= key_len;
            count_q      <= '0;
            keys_ready_q <= 1'b0;
            if (key_len == KEY_LEN_NONE) begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end else begin
               state_q <= ST_LOAD;
               busy_q  <= 1'b1;
            end
         end else begin
            if (wr_acc) valid_q[wr_addr] <= 1'b1;
            if (wr_new) count_q <= count_q + ADDR_W'(1);
            if (state_q == ST_LOAD && full) begin
               state_q      <= ST_READY;
               busy_q       <= 1'b0;
               keys_ready_q <= 1'b1;
            end
         end
      end
   end

   round_key_ram #(
      .W  (SUBKEY_W),
      .D  (DEPTH),
      .AW (ADDR_W)
   ) u_ram (
      .clk_i      (clk),
      .rst_ni     (reset),
      .we_i       (wr_acc),
      .waddr_i    (wr_addr),
      .wdata_i    (wr_data),
      .re_i       (rd_hit || rd_fwd),
      .raddr_i    (rd_addr),
      .fwd_i      (rd_fwd),
      .fwd_data_i (wr_data),
      .rdata_o    (rd_data)
   );

   assign rd_valid   = rd_valid_q;
   assign rd_err     = rd_err_q;
   assign keys_ready = keys_ready_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_round_key_store.sv
// Bench for round_key_store: vector table, directed corner sequences,
// and random traffic against a behavioural model.
module tb_round_key_store;
`ifdef ROUND_KEY_STORE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         clr = 1'b0;
   logic [1:0]   len = 2'b00;
   logic         we = 1'b0;
   logic [3:0]   wa = '0;
   logic [127:0] wd = '0;
   logic         re = 1'b0;
   logic [3:0]   ra = '0;
   logic         rd_stall, rd_valid, rd_err, keys_ready, busy;
   logic [127:0] rd_data;

   int    total = 0;
   int    bad = 0;
   string ph = "init";

   always #5 clk = ~clk;

   round_key_store dut (
      .clk        (clk),
      .reset      (reset),
      .wr_clear   (clr),
      .key_len    (len),
      .wr_en      (we),
      .wr_addr    (wa),
      .wr_data    (wd),
      .rd_req     (re),
      .rd_addr    (ra),
      .rd_stall   (rd_stall),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_err     (rd_err),
      .keys_ready (keys_ready),
      .busy       (busy)
   );

   // Behavioural model: which keys are present, and what the port shows.
   logic [127:0] m_mem [15];
   bit   [14:0]  m_val;
   logic [1:0]   m_len;
   bit           m_loading, m_ready, m_rdv, m_err;
   logic [127:0] m_rdd;

   function automatic int m_last();
      case (m_len)
         2'b01:   return 10;
         2'b10:   return 12;
         2'b11:   return 14;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_all(input int lst);
      for (int i = 0; i <= lst; i++)
         if (!m_val[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_reset();
      m_val = '0; m_len = 2'b00;
      m_loading = 0; m_ready = 0;
      m_rdv = 0; m_err = 0; m_rdd = '0;
   endtask

   function automatic bit m_stall();
      int lst = m_last();
      if (!re) return 1'b0;
      if (clr) return 1'b1;
      if (!(m_loading || m_ready) || int'(ra) > lst) return 1'b0;
      if (m_val[ra]) return 1'b0;
      if (BYP && m_loading && we && wa == ra) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_edge();
      int lst;
      bit act, done;
      lst = m_last();
      act = m_loading || m_ready;
      if (clr) begin
         m_val = '0; m_len = len; m_ready = 0;
         m_loading = (len != 2'b00);
         m_rdv = 0; m_err = 0;
         return;
      end
      m_rdv = 0; m_err = 0;
      if (re) begin
         if (!act || int'(ra) > lst) m_err = 1;
         else if (m_val[ra]) begin
            m_rdv = 1; m_rdd = m_mem[ra];
         end else if (BYP && m_loading && we && wa == ra) begin
            m_rdv = 1; m_rdd = wd;
         end
      end
      done = m_loading && m_all(lst);
      if (m_loading && we && int'(wa) <= lst) begin
         m_mem[wa] = wd; m_val[wa] = 1'b1;
      end
      if (done) begin
         m_loading = 0; m_ready = 1;
      end
   endtask

   task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s/%s got=%h want=%h", ph, nm, act, exp);
      end
   endtask

   function automatic logic [127:0] key_of(input int a, input int s);
      logic [31:0] w;
      w = 32'hC0DE0000 + 32'(a) + 32'(s << 8);
      return {w, ~w, w ^ 32'h5A5A5A5A, w + 32'd7};
   endfunction

   // One clock: drive at posedge+1, check stall, step, check registered outputs.
   task automatic cyc(input bit c, input bit [1:0] l, input bit w, input int a,
                      input logic [127:0] d, input bit r, input int b, output logic st);
      clr = c; len = l; we = w; wa = a[3:0]; wd = d; re = r; ra = b[3:0];
      #1;
      st = rd_stall;
      chk("stall", rd_stall, m_stall());
      @(posedge clk);
      m_edge();
      #1;
      chk("ctrl", {rd_valid, rd_err, keys_ready, busy}, {m_rdv, m_err, m_ready, m_loading});
      chk("data", rd_data, m_rdd);
   endtask

   task automatic wr(input int a, input int s);
      logic st;
      cyc(0, 0, 1, a, key_of(a, s), 0, 0, st);
   endtask

   task automatic nop();
      logic st;
      cyc(0, 0, 0, 0, '0, 0, 0, st);
   endtask

   typedef struct {
      bit c; bit [1:0] l; bit w; int a; bit r; int b;
      bit s; bit v; bit e; bit k; bit y;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(bit c, bit [1:0] l, bit w, int a, bit r, int b,
                               bit s, bit v, bit e, bit k, bit y);
      vec_t t;
      t.c = c; t.l = l; t.w = w; t.a = a; t.r = r; t.b = b;
      t.s = s; t.v = v; t.e = e; t.k = k; t.y = y;
      return t;
   endfunction

   initial begin
      logic st;
      int   extra;
      m_reset();
      #12;
      ph = "reset";
      chk("outs", {rd_valid, rd_err, keys_ready, busy, rd_stall}, '0);
      chk("rdata", rd_data, '0);
      @(posedge clk); #1;
      reset = 1'b1;

      // 128-bit load, back-to-back reads, out-of-range read
      tv.push_back(mk(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      for (int a = 0; a <= 10; a++)
         tv.push_back(mk(0, 0, 1, a, 0, 0, 0, 0, 0, 0, 1));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      for (int a = 0; a <= 10; a++)
         tv.push_back(mk(0, 0, 0, 0, 1, a, 0, 1, 0, 1, 0));
      tv.push_back(mk(0, 0, 0, 0, 1, 12, 0, 0, 1, 1, 0));
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      ph = "table";
      foreach (tv[i]) begin
         cyc(tv[i].c, tv[i].l, tv[i].w, tv[i].a, key_of(tv[i].a, 0),
             tv[i].r, tv[i].b, st);
         chk($sformatf("T%0d_stall", i), st, tv[i].s);
         chk($sformatf("T%0d_out", i), {rd_valid, rd_err, keys_ready, busy},
             {tv[i].v, tv[i].e, tv[i].k, tv[i].y});
         if (tv[i].v) chk($sformatf("T%0d_data", i), rd_data, key_of(tv[i].b, 0));
      end

      // 256-bit load with a read of entry 7 held until it lands
      ph = "stall";
      cyc(1, 2'b11, 0, 0, '0, 0, 0, st);
      for (int a = 0; a <= 6; a++) wr(a, 1);
      for (int a = 8; a <= 10; a++) begin
         cyc(0, 0, 1, a, key_of(a, 1), 1, 7, st);
         chk("held", st, 1'b1);
      end
      cyc(0, 0, 1, 7, key_of(7, 1), 1, 7, st);
      chk("wcycle_stall", st, !BYP);
      extra = 0;
      while (!rd_valid && extra < 4) begin
         cyc(0, 0, 0, 0, '0, 1, 7, st);
         extra++;
      end
      chk("latency", extra, BYP ? 0 : 1);
      chk("key7", rd_data, key_of(7, 1));
      for (int a = 11; a <= 14; a++) wr(a, 1);
      nop();
      chk("ready256", keys_ready, 1'b1);

      // 192-bit load with a duplicated index
      ph = "rewrite";
      cyc(1, 2'b10, 0, 0, '0, 0, 0, st);
      wr(3, 9);
      wr(3, 2);
      for (int a = 0; a <= 11; a++)
         if (a != 3) wr(a, 2);
      nop();
      chk("not_ready", {keys_ready, busy}, 2'b01);
      wr(12, 2);
      nop();
      chk("ready192", {keys_ready, busy}, 2'b10);
      cyc(0, 0, 0, 0, '0, 1, 3, st);
      chk("key3", rd_data, key_of(3, 2));

      // clear collides with a write and a read
      ph = "clear";
      cyc(1, 2'b01, 1, 5, key_of(5, 4), 1, 0, st);
      chk("clr_stall", st, 1'b1);
      chk("clr_out", {rd_valid, keys_ready, busy}, 3'b001);
      cyc(0, 0, 0, 0, '0, 1, 5, st);
      chk("dropped5", st, 1'b1);
      cyc(0, 0, 0, 0, '0, 1, 0, st);
      chk("empty0", st, 1'b1);

      // reset in the middle of a load
      ph = "midreset";
      cyc(1, 2'b01, 0, 0, '0, 0, 0, st);
      for (int a = 0; a <= 5; a++) wr(a, 6);
      cyc(0, 0, 0, 0, '0, 1, 0, st);
      chk("pre", {rd_valid, busy}, 2'b11);
      clr = 0; we = 0; re = 0;
      #2 reset = 1'b0;
      m_reset();
      #1;
      chk("async_outs", {rd_valid, rd_err, keys_ready, busy}, '0);
      chk("async_data", rd_data, '0);
      @(posedge clk); #1;
      reset = 1'b1;
      cyc(0, 0, 0, 0, '0, 1, 0, st);
      chk("idle_err", {rd_err, rd_valid, st}, 3'b100);

      // random traffic
      ph = "random";
      for (int n = 0; n < 3000; n++) begin
         bit c;
         c = ($urandom % 40) == 0;
         cyc(c, 2'($urandom), ($urandom % 3) != 0, int'($urandom % 16),
             {$urandom, $urandom, $urandom, $urandom},
             $urandom % 2 == 1, int'($urandom % 16), st);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/round_key_store.md
Name: round_key_store

Overview:
- Downstream consumer of the key-expansion stage.
- Captures the per-round subkeys it emits (valid/waddr/subkey, cleared by reset_valid_bits) into a 15-entry x 128-bit store with per-entry valid bits.
- Serves the round pipeline through a one-cycle-latency read port with stall when a requested key is not yet written.
- Signals keys_ready once all Nr+1 subkeys for the latched key length are present.

Parameters:
- SUBKEY_W, 128, width of one round key
- DEPTH, 15, number of entries (max Nr+1 for AES-256)
- ADDR_W, 4, address width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous active-low reset
- wr_clear  input  1  pulse from key expansion reset_valid_bits; clear store and start a new load
- key_len  input  2  01=128, 10=192, 11=256, 00=none; sampled on wr_clear
- wr_en  input  1  subkey valid from key expansion
- wr_addr  input  ADDR_W  round index of wr_data
- wr_data  input  SUBKEY_W  subkey
- rd_req  input  1  round pipeline requests a key
- rd_addr  input  ADDR_W  round index requested
- rd_stall  output  1  combinational; rd_req present but not accepted this cycle
- rd_valid  output  1  registered; rd_data holds requested key
- rd_data  output  SUBKEY_W  registered key
- rd_err  output  1  registered one-cycle pulse; out-of-range or no-key request
- keys_ready  output  1  registered; all entries 0..LAST valid
- busy  output  1  registered; state == LOAD

Behaviour:
- LAST = 10 / 12 / 14 for key_len 01 / 10 / 11. key_len 00 means no key.
- Reset (reset low, async):
  - valid[14:0]=0, state=IDLE, key_len_reg=00, fill count=0.
  - rd_valid=0, rd_data=0, rd_err=0, keys_ready=0, busy=0.
  - Storage array is not reset.
- States:
  - IDLE -> LOAD on wr_clear with key_len != 00.
  - LOAD -> READY the cycle after fill count reaches LAST+1.
  - Any state -> LOAD (or IDLE if key_len=00) on wr_clear.
- wr_clear (posedge):
  - valid bits cleared, key_len_reg <= key_len, count=0, keys_ready=0.
  - Dominates a same-cycle wr_en (the write is dropped) and a same-cycle rd_req (not accepted; rd_stall=1).
- Writes:
  - Accepted only in LOAD with wr_addr <= LAST.
  - Entry written, valid set. Count increments only if the entry was previously invalid, so rewriting the same index does not double-count.
  - Ignored in IDLE/READY and for wr_addr > LAST.
- Reads: a request hits when state != IDLE, rd_addr <= LAST and valid[rd_addr]=1.
  - Hit: rd_valid=1 and rd_data=entry on the next edge; rd_stall=0.
  - Miss, in range (key not yet written): rd_stall=1, no rd_valid. The requester holds rd_req/rd_addr stable until accepted.
  - Out of range, or state IDLE: rd_stall=0, rd_err pulses on the next cycle, rd_valid=0.
  - Back-to-back hits: one key per cycle.
  - rd_data holds its last value when rd_valid=0.
- keys_ready rises one cycle after the final accepted write and stays high until wr_clear or reset.
- Reset asserted mid-load: all state lost. Deassertion returns to IDLE; the load must be restarted with wr_clear.

Optional Feature:
- Macro: ROUND_KEY_STORE_BYPASS_EN.
- Defined: an in-range miss whose rd_addr equals a same-cycle accepted write (wr_en, LOAD, wr_addr == rd_addr, no wr_clear) is accepted. wr_data is forwarded: rd_valid=1 and rd_data=wr_data the next cycle, rd_stall=0.
- Undefined: that request stalls one cycle and hits on the following cycle.

Decomposition:
- Package aes_key_pkg:
  - KEY_LEN_NONE/128/192/256 encodings
  - SUBKEY_W, KS_DEPTH, KS_ADDR_W
  - state typedef {IDLE, LOAD, READY}
  - function last_round(key_len) returning 10/12/14
- Sub-module round_key_ram: 15x128 register array with one write port and one registered read port, no reset. The control FSM, valid bits, counter and handshake stay in round_key_store.

Test Plan:
- Reset, then wr_clear with key_len=01, then writes to addr 0..10 one per cycle -> busy=1 during load; keys_ready=1 exactly one cycle after addr 10; state READY.
- After a 128-bit load, rd_req addr 0..10 back-to-back -> rd_valid each cycle, rd_data matches written keys, latency 1. Then rd_req addr 12 -> rd_err pulse, no rd_valid.
- key_len=11 load: rd_req addr 7 held from before addr 7 is written -> rd_stall=1 until the write. Bypass undefined: rd_valid one cycle after the write-visible cycle. Bypass defined: rd_valid the cycle after the write, data=wr_data.
- Rewrite addr 3 twice during a key_len=10 load, then write the remaining 12 entries -> keys_ready only after all 13 distinct entries (0..12).
- wr_clear same cycle as wr_en addr 5 and rd_req addr 0 in READY -> write dropped, read not accepted (rd_stall=1), valid all 0, keys_ready=0 next cycle.
- reset low mid-load after 6 writes -> outputs 0 immediately. After release, rd_req addr 0 -> rd_err (IDLE).
